// File: rtl/lfsr_cipher_pkg.sv
// Shared definitions for the LFSR message cipher: tap table, pad character,
// next-state function and the decrypter state encoding.
package lfsr_cipher_pkg;

    localparam logic [7:0] PAD_CHAR = 8'h20;

    localparam logic [7:0] TAP_TABLE [8] = '{
        8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PROBE  = 3'd2,
        DEC_RD = 3'd3,
        DEC_WR = 3'd4,
        PAD    = 3'd5,
        DONE   = 3'd6
    } dec_state_t;

    // Shift left, feedback bit is the parity of the tapped state bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] p);
        return {s[6:0], ^(s & p)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR advance for a tap pattern selected from the shared table.
module lfsr_step
    import lfsr_cipher_pkg::*;
(
    input  logic [7:0] state,
    input  logic [2:0] tap_sel,
    output logic [7:0] next_state
);

    assign next_state = lfsr_next(state, TAP_TABLE[tap_sel]);

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// Recovers LFSR seed/taps from the space preamble of an encrypted frame and
// writes the decrypted, left-stripped message back to the plaintext area.
module lfsr_decrypt_engine
    import lfsr_cipher_pkg::*;
#(
    parameter int CRYPT_BASE = 64,
    parameter int PLAIN_BASE = 0,
    parameter int FRAME_LEN  = 64,
    parameter int MSG_LEN    = 41,
    parameter int PROBE_LEN  = 8
)
(
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    input  logic [7:0] mem_rd_data,
    output logic       done,
    output logic       err,
    output logic [2:0] tap_idx,
    output logic [7:0] lfsr_init,
    output dec_state_t fsm_state
);

    localparam logic [7:0] CRYPT_B   = 8'(CRYPT_BASE);
    localparam logic [7:0] PLAIN_B   = 8'(PLAIN_BASE);
    localparam logic [6:0] FRAME_I   = 7'(FRAME_LEN);
    localparam logic [5:0] MSG_W     = 6'(MSG_LEN);
    localparam logic [2:0] PROBE_END = 3'(PROBE_LEN - 1);

    dec_state_t state;
    logic [2:0] k;
    logic [2:0] step;
    logic [2:0] pi;
    logic [6:0] i;
    logic [5:0] w;
    logic [7:0] s;
    logic       skipping;
    logic [7:0] probe_buf [8];

    logic [2:0] tap_sel;
    logic [7:0] s_next;
    logic [7:0] plain_byte;
    logic [5:0] w_step;
    logic [6:0] i_inc;

    // One stepper serves both the tap search and the keystream.
    assign tap_sel    = (state == PROBE) ? pi : tap_idx;
    assign plain_byte = mem_rd_data ^ s;
    assign w_step     = w + {5'd0, mem_wr_en};
    assign i_inc      = i + 7'd1;
    assign fsm_state  = state;

    lfsr_step u_step (
        .state      (s),
        .tap_sel    (tap_sel),
        .next_state (s_next)
    );

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state       <= IDLE;
            mem_addr    <= 8'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            tap_idx     <= 3'd0;
            lfsr_init   <= 8'd0;
            k           <= 3'd0;
            step        <= 3'd0;
            pi          <= 3'd0;
            i           <= 7'd0;
            w           <= 6'd0;
            s           <= 8'd0;
            skipping    <= 1'b0;
            for (int n = 0; n < 8; n++) probe_buf[n] <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        k        <= 3'd0;
                        mem_addr <= CRYPT_B;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                LOAD: begin
                    probe_buf[k] <= mem_rd_data ^ PAD_CHAR;
                    if (k == PROBE_END) begin
                        state <= PROBE;
                        pi    <= 3'd0;
                        step  <= 3'd1;
                        s     <= probe_buf[0];
                    end else begin
                        k        <= k + 3'd1;
                        mem_addr <= CRYPT_B + 8'(k) + 8'd1;
                    end
                end
                PROBE: begin
                    if (s_next != probe_buf[step]) begin
                        if (pi == 3'd7) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pi   <= pi + 3'd1;
                            step <= 3'd1;
                            s    <= probe_buf[0];
                        end
                    end else if (step == PROBE_END) begin
                        tap_idx   <= pi;
                        lfsr_init <= probe_buf[0];
                        s         <= probe_buf[0];
                        i         <= 7'd0;
                        w         <= 6'd0;
                        skipping  <= 1'b1;
                        mem_addr  <= CRYPT_B;
                        state     <= DEC_RD;
                    end else begin
                        step <= step + 3'd1;
                        s    <= s_next;
                    end
                end
                DEC_RD: begin
                    // The write decision is made here so the strobe is registered for DEC_WR.
                    state <= DEC_WR;
                    if (skipping && plain_byte == PAD_CHAR) begin
                        mem_wr_en <= 1'b0;
                    end else begin
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= PLAIN_B + 8'(w);
                        mem_wr_data <= plain_byte;
                    end
                end
                DEC_WR: begin
                    s <= s_next;
                    i <= i_inc;
                    w <= w_step;
                    if (mem_wr_en) skipping <= 1'b0;
                    if (w_step == MSG_W || i_inc == FRAME_I) begin
                        state <= PAD;
                        if (w_step < MSG_W) begin
                            mem_wr_en   <= 1'b1;
                            mem_addr    <= PLAIN_B + 8'(w_step);
                            mem_wr_data <= PAD_CHAR;
                        end else begin
                            mem_wr_en <= 1'b0;
                        end
                    end else begin
                        state     <= DEC_RD;
                        mem_wr_en <= 1'b0;
                        mem_addr  <= CRYPT_B + 8'(i_inc);
                    end
                end
                PAD: begin
                    if (mem_wr_en) begin
                        w <= w_step;
                        if (w_step < MSG_W) begin
                            mem_addr <= PLAIN_B + 8'(w_step);
                        end else begin
                            mem_wr_en <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Bench for lfsr_decrypt_engine: encrypts frames into a memory model and
// compares the decrypter's outputs and plaintext area with a reference model.
module tb_lfsr_decrypt_engine;
    import lfsr_cipher_pkg::*;

    localparam logic [7:0] TAPS [8] = '{
        8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
    };
    localparam logic [7:0] FILL = 8'haa;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       done;
    logic       err;
    logic [2:0] tap_idx;
    logic [7:0] lfsr_init;
    dec_state_t fsm_state;

    logic [7:0] dm [256];
    int         wr_count = 0;
    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] msg_buf [64];
    int         msg_len;
    logic [7:0] exp_mem [64];
    logic [7:0] exp_q [$];
    logic       exp_err;
    logic [2:0] exp_tap;
    logic [7:0] exp_init;
    int         exp_writes;
    int         last_lat;

    lfsr_decrypt_engine dut (
        .clk         (clk),
        .init        (init),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .done        (done),
        .err         (err),
        .tap_idx     (tap_idx),
        .lfsr_init   (lfsr_init),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = dm[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            dm[mem_addr] = mem_wr_data;
            wr_count++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] step_fn(input logic [7:0] s, input logic [7:0] p);
        return {s[6:0], ^(s & p)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_msg(input string m);
        msg_len = m.len();
        for (int n = 0; n < msg_len; n++) msg_buf[n] = m[n];
    endtask

    task automatic set_random_msg();
        msg_len = $urandom_range(1, 41);
        for (int n = 0; n < msg_len; n++)
            msg_buf[n] = 8'($urandom_range((n == 0) ? 33 : 32, 126));
    endtask

    // Frame = pre spaces + message + space pad, XORed with the keystream.
    task automatic build_frame(input int tp, input logic [7:0] seed, input int pre);
        logic [7:0] s;
        logic [7:0] p;
        s = seed;
        for (int n = 0; n < 64; n++) begin
            if (n < pre) p = 8'h20;
            else if (n - pre < msg_len) p = msg_buf[n - pre];
            else p = 8'h20;
            dm[64 + n] = p ^ s;
            s = step_fn(s, TAPS[tp]);
        end
        for (int n = 0; n < 64; n++) dm[n] = FILL;
    endtask

    // Reference: first tap whose keystream reproduces the 8 probe bytes, then
    // decrypt the whole frame, drop leading spaces and take 41 bytes padded.
    task automatic model();
        logic [7:0] key0;
        logic [7:0] s;
        logic [7:0] b;
        bit         ok;
        bit         started;
        key0     = dm[64] ^ 8'h20;
        exp_err  = 1'b1;
        exp_tap  = 3'd0;
        exp_init = 8'd0;
        for (int t = 0; t < 8 && exp_err; t++) begin
            ok = 1'b1;
            s  = key0;
            for (int j = 1; j < 8; j++) begin
                s = step_fn(s, TAPS[t]);
                if (s != (dm[64 + j] ^ 8'h20)) ok = 1'b0;
            end
            if (ok) begin
                exp_err  = 1'b0;
                exp_tap  = 3'(t);
                exp_init = key0;
            end
        end
        for (int n = 0; n < 64; n++) exp_mem[n] = FILL;
        exp_q.delete();
        exp_writes = 0;
        if (!exp_err) begin
            s = key0;
            started = 1'b0;
            for (int n = 0; n < 64; n++) begin
                b = dm[64 + n] ^ s;
                s = step_fn(s, TAPS[exp_tap]);
                if (started || b != 8'h20) begin
                    started = 1'b1;
                    if (exp_q.size() < 41) exp_q.push_back(b);
                end
            end
            while (exp_q.size() < 41) exp_q.push_back(8'h20);
            for (int n = 0; n < 41; n++) exp_mem[n] = exp_q[n];
            exp_writes = 41;
        end
    endtask

    task automatic run_and_check(input string tag, input bit poke, input int exp_lat);
        int cyc;
        bit poked;
        model();
        wr_count = 0;
        poked = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            if (poke && !poked && fsm_state == PROBE) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        last_lat = cyc;
        check($sformatf("%s done", tag), 32'(done), 32'd1);
        check($sformatf("%s latency<=242", tag), 32'(cyc <= 242), 32'd1);
        if (poke) check($sformatf("%s probe_poke", tag), 32'(poked), 32'd1);
        if (exp_lat != 0) check($sformatf("%s latency_same", tag), 32'(cyc), 32'(exp_lat));
        check($sformatf("%s err", tag), 32'(err), 32'(exp_err));
        if (!exp_err) begin
            check($sformatf("%s tap_idx", tag), 32'(tap_idx), 32'(exp_tap));
            check($sformatf("%s lfsr_init", tag), 32'(lfsr_init), 32'(exp_init));
        end
        check($sformatf("%s writes", tag), 32'(wr_count), 32'(exp_writes));
        for (int n = 0; n < 64; n++)
            check($sformatf("%s dm[%0d]", tag, n), 32'(dm[n]), 32'(exp_mem[n]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s mem_wr_en", tag), 32'(mem_wr_en), 32'd0);
        check($sformatf("%s done", tag), 32'(done), 32'd0);
        check($sformatf("%s err", tag), 32'(err), 32'd0);
        check($sformatf("%s mem_addr", tag), 32'(mem_addr), 32'd0);
        check($sformatf("%s mem_wr_data", tag), 32'(mem_wr_data), 32'd0);
        check($sformatf("%s tap_idx", tag), 32'(tap_idx), 32'd0);
        check($sformatf("%s lfsr_init", tag), 32'(lfsr_init), 32'd0);
        check($sformatf("%s state", tag), 32'(fsm_state), 32'(IDLE));
    endtask

    initial begin
        string s1;
        int    cyc;
        logic [7:0] inits [3];
        inits = '{8'h01, 8'h80, 8'hff};
        for (int n = 0; n < 256; n++) dm[n] = 8'h00;

        // Reset
        init = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        init = 1'b0;
        @(negedge clk);

        // Known message, taps d4 / seed 7f
        s1 = "Knowledge comes, but wisdom lingers.     ";
        set_msg(s1);
        build_frame(1, 8'h7f, 9);
        run_and_check("t1", 1'b0, 0);
        check("t1 tap_idx_direct", 32'(tap_idx), 32'd1);
        check("t1 lfsr_init_direct", 32'(lfsr_init), 32'h7f);
        for (int n = 0; n < 41; n++)
            check($sformatf("t1 text[%0d]", n), 32'(dm[n]), 32'(s1[n]));

        // Long run of leading spaces
        set_msg({{27{" "}}, "Ajok"});
        build_frame(6, 8'h5a, 10);
        run_and_check("t2", 1'b0, 0);
        check("t2 A", 32'(dm[0]), 32'h41);
        check("t2 j", 32'(dm[1]), 32'h6a);
        check("t2 o", 32'(dm[2]), 32'h6f);
        check("t2 k", 32'(dm[3]), 32'h6b);

        // Every tap pattern with edge seeds
        set_msg("Sweep over taps!");
        for (int t = 0; t < 8; t++)
            for (int m = 0; m < 3; m++) begin
                build_frame(t, inits[m], 9);
                run_and_check($sformatf("t3 tap%0d init%0h", t, inits[m]), 1'b0, 0);
            end

        // No valid preamble
        for (int n = 0; n < 64; n++) dm[64 + n] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 8; n++) dm[64 + n] = 8'(n);
        for (int n = 0; n < 64; n++) dm[n] = FILL;
        run_and_check("t4", 1'b0, 0);

        // Abort during the 21st message write, then a fresh frame
        set_msg(s1);
        build_frame(3, 8'h3c, 9);
        model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!(mem_wr_en === 1'b1 && fsm_state == DEC_WR && mem_addr == 8'd20) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("t5 reached_byte20", 32'(cyc < 300), 32'd1);
        init = 1'b1;
        #1;
        check_reset_outputs("t5 abort");
        @(negedge clk);
        init = 1'b0;
        for (int n = 0; n < 21; n++)
            check($sformatf("t5 kept dm[%0d]", n), 32'(dm[n]), 32'((n < 20) ? exp_mem[n] : FILL));
        set_random_msg();
        build_frame(5, 8'h99, 11);
        run_and_check("t5 fresh", 1'b0, 0);

        // start during PROBE must not restart the run
        set_random_msg();
        build_frame(7, 8'h42, 9);
        run_and_check("t6 ref", 1'b0, 0);
        build_frame(7, 8'h42, 9);
        run_and_check("t6 poke", 1'b1, last_lat);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            set_random_msg();
            build_frame($urandom_range(0, 7), 8'($urandom_range(1, 255)), $urandom_range(9, 12));
            run_and_check($sformatf("rnd%0d", r), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
